// File: rtl/imem_cmd_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_cmd_loader
// Purpose  : Host byte-load command responder with big-endian word fetch port.
//            Optional byte readback when IMEM_CMD_READ_EN is defined.
// Revision : 1.0
// ============================================================================
module imem_cmd_loader #(
    parameter int DEPTH   = 64,
    parameter int WORD_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         cmd,
    input  logic               cmd_valid,
    input  logic [7:0]         address,
    input  logic [7:0]         data_in,
    output logic               cmd_done,
    output logic [7:0]         data_out,
    input  logic               start_signal,
    input  logic [WORD_AW-1:0] cpu_pc,
    output logic [31:0]        cpu_instr,
    output logic               busy
);

    localparam int          c_nwords    = DEPTH / 4;
    localparam int          c_midx      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          c_widx      = (c_nwords > 1) ? $clog2(c_nwords) : 1;
    localparam logic [7:0]  c_cmd_write = 8'd2;
    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cmd_q, addr_q, wdata_q;
    logic [7:0]          mem_q [DEPTH];
    logic [31:0]         instr_q, instr_d;

    logic                w_accept;
    logic                w_addr_ok;
    logic [c_midx-1:0]   w_midx;
    logic                w_we;
    logic [31:0]         w_pc_ext;
    logic                w_fetch_ok;
    logic [31:0]         w_words [c_nwords];

    assign w_accept  = (state_q == ST_IDLE) && cmd_valid;
    // Compare in 9 bits so DEPTH=256 is representable and high addresses never alias.
    assign w_addr_ok = ({1'b0, addr_q} < 9'(DEPTH));
    assign w_midx    = addr_q[c_midx-1:0];
    assign w_we      = (state_q == ST_EXEC) && (cmd_q == c_cmd_write)
                       && w_addr_ok && !start_signal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cmd_valid)  state_d = ST_EXEC;
            ST_EXEC:                 state_d = ST_DONE;
            ST_DONE: if (!cmd_valid) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= 8'h00;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
        end else if (w_accept) begin
            cmd_q   <= cmd;
            addr_q  <= address;
            wdata_q <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (w_we) begin
            mem_q[w_midx] <= wdata_q;
        end
    end

    // Lowest byte address lands in the most significant byte of the word.
    for (genvar k = 0; k < c_nwords; k++) begin : g_word
        assign w_words[k] = {mem_q[4*k], mem_q[4*k+1], mem_q[4*k+2], mem_q[4*k+3]};
    end

    assign w_pc_ext   = 32'(cpu_pc);
    assign w_fetch_ok = (w_pc_ext < 32'(c_nwords));

    always_comb begin
        instr_d = c_nop_instr;
        if (w_fetch_ok) begin
            instr_d = w_words[cpu_pc[c_widx-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= c_nop_instr;
        end else begin
            instr_q <= instr_d;
        end
    end

`ifdef IMEM_CMD_READ_EN
    localparam logic [7:0] c_cmd_read = 8'd1;

    logic [7:0] dout_q, dout_d;
    logic       w_re;

    assign w_re = (state_q == ST_EXEC) && (cmd_q == c_cmd_read);

    always_comb begin
        dout_d = dout_q;
        if (w_re) begin
            dout_d = w_addr_ok ? mem_q[w_midx] : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= 8'h00;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign data_out = dout_q;
`else
    assign data_out = 8'h00;
`endif

    assign cmd_done  = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign cpu_instr = instr_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_cmd_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imem_cmd_loader
// Purpose  : Scoreboard bench for imem_cmd_loader (directed + random commands).
// Revision : 1.0
// ============================================================================
module tb_imem_cmd_loader;

    localparam int          DEPTH   = 64;
    localparam int          WORD_AW = 5;
    localparam logic [31:0] NOP     = 32'h0000_0013;
`ifdef IMEM_CMD_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         cmd = 8'h00;
    logic               cmd_valid = 1'b0;
    logic [7:0]         address = 8'h00;
    logic [7:0]         data_in = 8'h00;
    logic               cmd_done;
    logic [7:0]         data_out;
    logic               start_signal = 1'b0;
    logic [WORD_AW-1:0] cpu_pc = '0;
    logic [31:0]        cpu_instr;
    logic               busy;

    always #5 clk = ~clk;

    imem_cmd_loader #(.DEPTH(DEPTH), .WORD_AW(WORD_AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .address      (address),
        .data_in      (data_in),
        .cmd_done     (cmd_done),
        .data_out     (data_out),
        .start_signal (start_signal),
        .cpu_pc       (cpu_pc),
        .cpu_instr    (cpu_instr),
        .busy         (busy)
    );

    typedef struct {
        logic [7:0] dout;
        int         cyc;
    } exp_t;

    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    logic [7:0]   ref_mem [256];
    logic [7:0]   ref_dout = 8'h00;
    exp_t         cmd_exp [$];
    logic [31:0]  fetch_exp [$];
    logic [31:0]  fexp;
    exp_t         cx;
    logic         prev_done = 1'b0;
    bit           pc_rand = 1'b0;
    logic [WORD_AW-1:0] pc_fixed = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] ref_fetch(input int p);
        if (4 * p + 3 >= DEPTH) return NOP;
        return {ref_mem[4*p], ref_mem[4*p+1], ref_mem[4*p+2], ref_mem[4*p+3]};
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_dout = 8'h00;
    endtask

    // Expected fetch word is taken from the model as it stands at the capturing edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) fetch_exp.push_back(NOP);
        else        fetch_exp.push_back(ref_fetch(int'(cpu_pc)));
    end

    always @(negedge clk) begin
        if (fetch_exp.size() > 0) begin
            fexp = fetch_exp.pop_front();
            check("fetch", cpu_instr, rst_n ? fexp : NOP);
        end
        if (rst_n && cmd_done && !prev_done) begin
            if (cmd_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got cmd_done=1 expected no pending command at %0t", $time);
            end else begin
                cx = cmd_exp.pop_front();
                check("data_out", 32'(data_out), 32'(cx.dout));
                check("done_latency", cyc, cx.cyc);
            end
        end
        prev_done <= cmd_done;
    end

    initial begin
        forever begin
            @(negedge clk);
            cpu_pc = pc_rand ? WORD_AW'($urandom) : pc_fixed;
        end
    end

    task automatic host_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                            input int hold, input bit flip, input int gap);
        exp_t e;
        @(negedge clk);
        cmd = c; address = a; data_in = d; cmd_valid = 1'b1;
        if (READ_EN && c == 8'd1) ref_dout = (a < DEPTH) ? ref_mem[a] : 8'h00;
        e.dout = ref_dout;
        e.cyc  = cyc + 2;
        cmd_exp.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cmd = 8'($urandom); address = 8'($urandom); data_in = 8'($urandom);
        if (flip) start_signal = ~start_signal;
        @(posedge clk);
        @(negedge clk);
        if (c == 8'd2 && a < DEPTH && !start_signal) ref_mem[a] = d;
        check("busy_in_done", 32'(busy), 32'd1);
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            check("done_held", 32'(cmd_done), 32'd1);
        end
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("done_cleared", 32'(cmd_done), 32'd0);
        check("busy_cleared", 32'(busy), 32'd0);
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int r;
        logic [7:0] c, a;
        ref_clear();
        repeat (2) @(negedge clk);
        check("rst_cmd_done", 32'(cmd_done), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_instr", cpu_instr, NOP);
        #2 rst_n = 1'b1;

        // Program word 0 with a known instruction.
        host_cmd(8'd2, 8'd0, 8'h00, 2, 1'b0, 7);
        host_cmd(8'd2, 8'd1, 8'h50, 2, 1'b0, 7);
        host_cmd(8'd2, 8'd2, 8'h01, 2, 1'b0, 7);
        host_cmd(8'd2, 8'd3, 8'h13, 2, 1'b0, 7);
        pc_fixed = '0;
        repeat (3) @(negedge clk);
        check("instr_pc0", cpu_instr, 32'h0050_0113);

        host_cmd(8'd2, 8'd8, 8'hA5, 8, 1'b0, 2);

        start_signal = 1'b1;
        host_cmd(8'd2, 8'd0, 8'hFF, 1, 1'b0, 2);
        start_signal = 1'b0;
        repeat (3) @(negedge clk);
        check("locked_pc0", cpu_instr, 32'h0050_0113);

        host_cmd(8'd2, 8'd64, 8'h77, 0, 1'b0, 2);
        pc_fixed = 5'd15;
        repeat (3) @(negedge clk);
        check("instr_pc15", cpu_instr, 32'h0000_0000);
        pc_fixed = 5'd16;
        repeat (3) @(negedge clk);
        check("instr_pc16_nop", cpu_instr, NOP);
        pc_fixed = 5'd2;
        repeat (3) @(negedge clk);
        check("instr_pc2", cpu_instr, 32'hA500_0000);

        host_cmd(8'd1, 8'd1, 8'h00, 1, 1'b0, 2);
        check("read_addr1", 32'(data_out), READ_EN ? 32'h50 : 32'h00);

        // Reset while the write sits in EXEC: the write must be lost.
        pc_fixed = '0;
        @(negedge clk);
        cmd = 8'd2; address = 8'd2; data_in = 8'hEE; cmd_valid = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        ref_clear();
        check("rst_exec_done", 32'(cmd_done), 32'd0);
        check("rst_exec_busy", 32'(busy), 32'd0);
        check("rst_exec_instr", cpu_instr, NOP);
        cmd_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_byte_cleared", cpu_instr, 32'h0000_0000);

        pc_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)       c = 8'd2;
            else if (r < 7)  c = 8'd1;
            else if (r == 7) c = 8'd0;
            else             c = 8'($urandom_range(3, 255));
            a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
            start_signal = ($urandom_range(0, 4) == 0);
            host_cmd(c, a, 8'($urandom), int'($urandom_range(0, 3)),
                     ($urandom_range(0, 4) == 0), int'($urandom_range(0, 2)));
        end
        start_signal = 1'b0;
        pc_rand = 1'b0;
        repeat (4) @(negedge clk);

        checks++;
        if (cmd_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending commands expected 0", cmd_exp.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
